// File: rtl/mixer_pkg.sv
// mixer_pkg: shared state enum, sample rails and accumulator width helper for sample_mixer
package mixer_pkg;
  typedef enum logic {SYNC, ACCUM} MixerState_t;
  localparam logic signed [15:0] SAMPLE_MAX = 16'sh7fff;
  localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;
  function automatic int acc_width(int voices);
    return 16 + $clog2(voices);
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO (push/full in, dout/valid/ready out), full pushes are dropped
module sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};
  logic [W-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  logic wr, rd;
  assign valid = wp != rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign wr = push && !full;
  assign rd = valid && ready;
  assign dout = mem[rp[PW-1:0]];
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wp <= '0;
      rp <= '0;
      mem <= '{default: '0};
    end else begin
      if (wr) begin
        mem[wp[PW-1:0]] <= din;
        wp <= wp + ONE;
      end
      if (rd) rp <= rp + ONE;
    end
  end
endmodule

// File: rtl/sample_mixer.sv
// sample_mixer: sums a frame of subsamples, shifts/saturates to 16 bits, FIFO to valid/ready output; SAMPLE_MIXER_CLIP_COUNT_EN enables o_ClipCount
module sample_mixer
  import mixer_pkg::*;
#(
  parameter int VOICES = 16,
  parameter int SHIFT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic signed [15:0] i_Subsample,
  input  logic               i_SubsampleReady,
  input  logic               i_SampleReady,
  output logic signed [15:0] o_Sample,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic               o_Overrun,
  output logic               o_FrameError,
  output logic [15:0]        o_ClipCount
);
  localparam int AW = acc_width(VOICES);
  localparam int CW = $clog2(VOICES) + 1;
  localparam logic signed [AW-1:0] AMAX = AW'(SAMPLE_MAX);
  localparam logic signed [AW-1:0] AMIN = AW'(SAMPLE_MIN);
  MixerState_t state, state_n;
  logic signed [AW-1:0] acc, mix, sub_ext, sum, shifted;
  logic [CW-1:0] cnt, cnt_n;
  logic mix_vld, full, clip;
  logic [15:0] sat;
  assign sub_ext = i_SubsampleReady ? AW'(i_Subsample) : '0;
  assign sum = acc + sub_ext;
  assign cnt_n = cnt + CW'(i_SubsampleReady);
  assign shifted = mix >>> SHIFT;
  // landing exactly on a rail also counts as clipped
  assign clip = (shifted >= AMAX) || (shifted <= AMIN);
  assign sat = shifted >= AMAX ? SAMPLE_MAX : shifted <= AMIN ? SAMPLE_MIN : shifted[15:0];
  always_comb state_n = (state == SYNC && i_SampleReady) ? ACCUM : state;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= SYNC;
      acc <= '0;
      cnt <= '0;
      mix <= '0;
      mix_vld <= 1'b0;
      o_Overrun <= 1'b0;
      o_FrameError <= 1'b0;
    end else begin
      state <= state_n;
      mix_vld <= 1'b0;
      o_Overrun <= mix_vld && full;
      if (state == SYNC) begin
        if (i_SampleReady) begin
          acc <= '0;
          cnt <= '0;
        end
      end else if (i_SampleReady) begin
        mix <= sum;
        mix_vld <= 1'b1;
        acc <= '0;
        cnt <= '0;
        if (cnt_n != CW'(VOICES)) o_FrameError <= 1'b1;
      end else begin
        acc <= sum;
        cnt <= cnt_n;
      end
    end
  end
`ifdef SAMPLE_MIXER_CLIP_COUNT_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset) o_ClipCount <= '0;
    else if (mix_vld && !full && clip && o_ClipCount != 16'hffff) o_ClipCount <= o_ClipCount + 16'd1;
  end
`else
  assign o_ClipCount = '0;
`endif
  sample_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .push(mix_vld),
    .din(sat),
    .ready(i_Ready),
    .dout(o_Sample),
    .valid(o_Valid),
    .full(full)
  );
endmodule

// File: tb/tb_sample_mixer.sv
// tb_sample_mixer: directed table-driven checks of sample_mixer framing, mixing, latency, overrun and flags
module tb_sample_mixer;
  logic i_Clock = 0, i_Reset = 1, sub_rdy = 0, smp_rdy = 0, i_Ready = 1;
  logic signed [15:0] sub = 0;
  logic signed [15:0] o_Sample;
  logic o_Valid, o_Overrun, o_FrameError;
  logic [15:0] o_ClipCount;
  int n_chk = 0, n_fail = 0;
`ifdef SAMPLE_MIXER_CLIP_COUNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  typedef struct {int v; int n; int last; int smp; int clips; int ferr;} vec_t;
  vec_t tv[9];
  sample_mixer dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Subsample(sub),
    .i_SubsampleReady(sub_rdy),
    .i_SampleReady(smp_rdy),
    .o_Sample(o_Sample),
    .o_Valid(o_Valid),
    .i_Ready(i_Ready),
    .o_Overrun(o_Overrun),
    .o_FrameError(o_FrameError),
    .o_ClipCount(o_ClipCount)
  );
  always #5 i_Clock = ~i_Clock;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask
  task automatic frame(int v, int n, int last);
    for (int i = 0; i < n; i++) begin
      sub = 16'(i == n - 1 ? last : v);
      sub_rdy = 1;
      smp_rdy = (i == n - 1);
      tick();
    end
    sub_rdy = 0;
    smp_rdy = 0;
    sub = 0;
  endtask
  initial begin
    tv[0] = '{100, 16, 100, 100, 0, 0};
    tv[1] = '{32767, 16, 32767, 32767, 1, 0};
    tv[2] = '{-32768, 16, -32768, -32768, 2, 0};
    tv[3] = '{0, 16, 160, 10, 2, 0};
    tv[4] = '{-1, 16, 0, -1, 2, 0};
    tv[5] = '{7, 16, 1, 6, 2, 0};
    tv[6] = '{30000, 16, 30000, 30000, 2, 0};
    tv[7] = '{100, 15, 100, 93, 2, 1};
    tv[8] = '{-100, 16, -100, -100, 2, 1};
    repeat (3) tick();
    chk("rst_sample", int'(o_Sample), 0);
    chk("rst_valid", int'(o_Valid), 0);
    chk("rst_overrun", int'(o_Overrun), 0);
    chk("rst_ferr", int'(o_FrameError), 0);
    chk("rst_clip", int'(o_ClipCount), 0);
    i_Reset = 0;
    frame(500, 8, 500);
    chk("partial_valid_n", int'(o_Valid), 0);
    tick();
    chk("partial_valid_n1", int'(o_Valid), 0);
    tick();
    for (int i = 0; i < 9; i++) begin
      frame(tv[i].v, tv[i].n, tv[i].last);
      chk($sformatf("v%0d_lat1", i), int'(o_Valid), 0);
      tick();
      chk($sformatf("v%0d_valid", i), int'(o_Valid), 1);
      chk($sformatf("v%0d_sample", i), int'(o_Sample), tv[i].smp);
      chk($sformatf("v%0d_ferr", i), int'(o_FrameError), tv[i].ferr);
      chk($sformatf("v%0d_clip", i), int'(o_ClipCount), tv[i].clips * CE);
      chk($sformatf("v%0d_ovr", i), int'(o_Overrun), 0);
      tick();
    end
    i_Ready = 0;
    for (int k = 1; k <= 5; k++) begin
      frame(k, 16, k);
      tick();
      chk($sformatf("bp%0d_ovr", k), int'(o_Overrun), k == 5 ? 1 : 0);
      chk($sformatf("bp%0d_valid", k), int'(o_Valid), 1);
      tick();
      chk($sformatf("bp%0d_ovr_end", k), int'(o_Overrun), 0);
    end
    i_Ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d", k), int'(o_Sample), k);
      tick();
    end
    chk("drain_empty", int'(o_Valid), 0);
    chk("bp_clip", int'(o_ClipCount), 2 * CE);
    chk("bp_ferr", int'(o_FrameError), 1);
    i_Ready = 0;
    frame(50, 16, 50);
    tick();
    chk("pre_rst_valid", int'(o_Valid), 1);
    i_Reset = 1;
    tick();
    i_Reset = 0;
    chk("rst2_valid", int'(o_Valid), 0);
    chk("rst2_ferr", int'(o_FrameError), 0);
    chk("rst2_clip", int'(o_ClipCount), 0);
    chk("rst2_sample", int'(o_Sample), 0);
    i_Ready = 1;
    frame(1600, 1, 1600);
    frame(1600, 1, 1600);
    chk("b2b_lat1", int'(o_Valid), 0);
    tick();
    chk("b2b_valid", int'(o_Valid), 1);
    chk("b2b_sample", int'(o_Sample), 100);
    chk("b2b_ferr", int'(o_FrameError), 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_mixer.md
# sample_mixer

Consumer end of the synthesis core's subsample stream. Sums the per-voice carrier subsamples of one sample frame, then scales and saturates the sum to a 16-bit mixed sample. Completed samples are buffered in a small FIFO and offered to the downstream output stage (DAC/serializer) over a valid/ready handshake. Sits directly between the core's `o_Subsample`/`o_SubsampleReady`/`o_SampleReady` outputs and the audio output path.

## Interface
- `VOICES`, 16: subsamples expected per frame.
- `SHIFT`, 4: arithmetic right shift applied to the frame sum before saturation.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two, at least 2.
- `i_Clock`  in  1  system clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Subsample`  in  16  signed subsample from the core.
- `i_SubsampleReady`  in  1  `i_Subsample` is valid this cycle.
- `i_SampleReady`  in  1  last subsample of the frame; coincides with the final `i_SubsampleReady`.
- `o_Sample`  out  16  signed mixed sample at the FIFO head.
- `o_Valid`  out  1  `o_Sample` is valid.
- `i_Ready`  in  1  downstream accepts `o_Sample` when `o_Valid && i_Ready`.
- `o_Overrun`  out  1  one-cycle pulse when a completed sample is dropped because the FIFO is full.
- `o_FrameError`  out  1  sticky flag: a frame closed with a subsample count other than `VOICES`.
- `o_ClipCount`  out  16  saturating count of clipped samples (see Configuration).

## Operation
- Accumulator width is `16 + clog2(VOICES)` bits, signed. Subsample counter width is `clog2(VOICES) + 1` bits.
- State machine:
  - `SYNC` is the reset state. Ignore all subsamples. On `i_SampleReady`, clear the accumulator and counter, then go to `ACCUM`. This discards the partial frame seen after reset.
  - `ACCUM`:
    - On each `i_SubsampleReady`, add the sign-extended `i_Subsample` to the accumulator and increment the counter.
    - On `i_SampleReady`, the same-cycle subsample is included in the final sum. The final sum is latched into the mix register, then the accumulator and counter restart at zero. The state stays `ACCUM`.
- Mix stage:
  - Shift the latched sum right arithmetically by `SHIFT`.
  - Saturate to the range [-32768, 32767].
  - A sample is clipped if it saturated.
- FIFO write:
  - Occurs the cycle after the mix register loads.
  - If the FIFO is full, drop the sample and pulse `o_Overrun`.
  - A write and a read in the same cycle on a full FIFO still drop the sample. Full is evaluated before the read.
- FIFO is first-word-fall-through. `o_Valid` means not empty. A read occurs on `o_Valid && i_Ready`. Read and write pointers wrap modulo `FIFO_DEPTH`.
- `o_FrameError` is set if the counter is not equal to `VOICES` at frame close in `ACCUM`, counting the closing subsample. It is cleared only by reset.
- Reset at any point returns to `SYNC` and empties the FIFO. Any in-flight mix is lost.
- Reset values of outputs: `o_Sample` 0, `o_Valid` 0, `o_Overrun` 0, `o_FrameError` 0, `o_ClipCount` 0.

## Timing
- Let cycle N be the clock edge that samples `i_SampleReady`. The mix register loads at N. The FIFO write occurs at N+1. `o_Valid` rises after N+1 when the FIFO was empty, so latency is 2 cycles.
- The core frame period is 96 cycles, so there is no back-to-back frame close. The design must still accept `i_SampleReady` on consecutive cycles without corruption.
- `o_Overrun` is asserted in the cycle following the dropped write edge, for exactly one cycle.
- `o_Sample` changes only after a read or after a write into an empty FIFO.

## Configuration
- `SAMPLE_MIXER_CLIP_COUNT_EN`:
  - Defined: `o_ClipCount` increments on each clipped sample that is written into the FIFO. It saturates at 65535. Dropped samples are not counted.
  - Undefined: the counter logic is omitted and `o_ClipCount` is tied to 0.

## Structure
- Shared package `mixer_pkg`:
  - state enum `MixerState_t` (`SYNC`, `ACCUM`);
  - `SAMPLE_MAX`/`SAMPLE_MIN` constants;
  - accumulator width function.
- One sub-module, `sample_fifo`, is natural: a parameterized FWFT FIFO with valid/ready read, push, and full/empty. The accumulator, mix stage, and flags stay in `sample_mixer`.

## Test plan
- **Alignment after reset:** release reset mid-frame, feed 7 subsamples, then `i_SampleReady`, then a full frame of 16 × 100. Expect no sample from the partial frame, one `o_Sample` = 100 (1600>>>4), and `o_FrameError` = 0.
- **Saturation:** feed a frame of 16 × 32767. Expect `o_Sample` = 32767 and `o_ClipCount` = 1 when enabled. Feed a frame of 16 × -32768. Expect -32768 and a clip count of 2 when enabled.
- **Latency and simultaneity:** feed 15 × 0 then a closing subsample of 160 on the `i_SampleReady` cycle. Expect `o_Valid` 2 cycles later with `o_Sample` = 10.
- **Backpressure and overrun:** hold `i_Ready` = 0 for 5 frames of value 16·k (k = 1..5) with `FIFO_DEPTH` = 4. Expect one `o_Overrun` pulse on the 5th frame. Draining then yields 1, 2, 3, 4.
- **Frame error:** close a frame after 15 subsamples. Expect `o_FrameError` = 1 and a sample still written. The flag holds through later good frames and clears on `i_Reset`.
